// File: rtl/cpl_arb_pkg.sv
// Shared types for the completion enqueue arbiter.
// Holds the arbiter FSM state and port index width helper.
package cpl_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  function automatic int cl_ports(input int ports);
    return (ports < 2) ? 1 : $clog2(ports);
  endfunction

endpackage

// File: rtl/cpl_enqueue_arbiter_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer.
// The pointer moves to the winner on advance.
module rr_arbiter #(
  parameter int PORTS = 4,
  parameter int IW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] req,
  input  logic             advance,
  output logic [PORTS-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_valid
);

  logic [IW-1:0] last;

  // Scan from farthest to nearest so the nearest request wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      if (req[(int'(last) + k) % PORTS]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(last) + k) % PORTS);
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(PORTS - 1);
    end else if (advance) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/cpl_enqueue_arbiter.sv
// Shares one completion-queue enqueue port among several sources.
// Tags requests with the source port and routes responses back.
module cpl_enqueue_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int PORTS             = 4,
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int OP_TAG_WIDTH      = 4,
  parameter int RESP_WIDTH        = 80,
  parameter int MAX_OUTSTANDING   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0]     s_req_queue,
  input  logic [PORTS*REQ_TAG_WIDTH-1:0]         s_req_tag,
  input  logic [PORTS-1:0]                       s_req_valid,
  output logic [PORTS-1:0]                       s_req_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]           m_req_queue,
  output logic [REQ_TAG_WIDTH+cl_ports(PORTS)-1:0] m_req_tag,
  output logic                                   m_req_valid,
  input  logic                                   m_req_ready,
  input  logic [RESP_WIDTH-1:0]                  s_resp_data,
  input  logic [REQ_TAG_WIDTH+cl_ports(PORTS)-1:0] s_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]                s_resp_op_tag,
  input  logic                                   s_resp_valid,
  output logic                                   s_resp_ready,
  output logic [PORTS*RESP_WIDTH-1:0]            m_resp_data,
  output logic [PORTS*REQ_TAG_WIDTH-1:0]         m_resp_tag,
  output logic [PORTS*OP_TAG_WIDTH-1:0]          m_resp_op_tag,
  output logic [PORTS-1:0]                       m_resp_valid,
  input  logic [PORTS-1:0]                       m_resp_ready,
  input  logic [PORTS*OP_TAG_WIDTH-1:0]          s_commit_op_tag,
  input  logic [PORTS-1:0]                       s_commit_valid,
  output logic [PORTS-1:0]                       s_commit_ready,
  output logic [OP_TAG_WIDTH-1:0]                m_commit_op_tag,
  output logic                                   m_commit_valid,
  input  logic                                   m_commit_ready,
  output logic [PORTS-1:0]                       outstanding_full
);

  localparam int CLP  = cl_ports(PORTS);
  localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_OUTSTANDING);
  localparam logic [CLP:0]    NPORTS  = (CLP+1)'(PORTS);

  // Keeps every ready low until the first edge after reset.
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  arb_state_t req_st, req_st_nxt;
  logic [PORTS-1:0] req_elig, req_gnt;
  logic [CLP-1:0]   req_idx, req_port_q;
  logic             req_gv, req_acc;
  logic [QUEUE_INDEX_WIDTH-1:0] req_queue_q;
  logic [REQ_TAG_WIDTH-1:0]     req_tag_q;

  assign req_elig = s_req_valid & ~outstanding_full;

  rr_arbiter #(
    .PORTS (PORTS),
    .IW    (CLP)
  ) u_req_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_elig),
    .advance     (req_acc),
    .grant       (req_gnt),
    .grant_idx   (req_idx),
    .grant_valid (req_gv)
  );

  assign req_acc     = run && (req_st == ARB_IDLE) && req_gv;
  assign s_req_ready = req_acc ? req_gnt : '0;

  always_comb begin
    req_st_nxt = req_st;
    unique case (req_st)
      ARB_IDLE: if (req_acc)     req_st_nxt = ARB_HOLD;
      ARB_HOLD: if (m_req_ready) req_st_nxt = ARB_IDLE;
      default:                   req_st_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_st      <= ARB_IDLE;
      req_queue_q <= '0;
      req_tag_q   <= '0;
      req_port_q  <= '0;
    end else begin
      req_st <= req_st_nxt;
      if (req_acc) begin
        req_queue_q <= s_req_queue[req_idx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
        req_tag_q   <= s_req_tag[req_idx*REQ_TAG_WIDTH +: REQ_TAG_WIDTH];
        req_port_q  <= req_idx;
      end
    end
  end

  assign m_req_valid = (req_st == ARB_HOLD);
  assign m_req_queue = req_queue_q;
  assign m_req_tag   = {req_port_q, req_tag_q};

  arb_state_t cmt_st, cmt_st_nxt;
  logic [PORTS-1:0] cmt_gnt;
  logic [CLP-1:0]   cmt_idx;
  logic             cmt_gv, cmt_acc;
  logic [OP_TAG_WIDTH-1:0] cmt_op_q;

  rr_arbiter #(
    .PORTS (PORTS),
    .IW    (CLP)
  ) u_cmt_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (s_commit_valid),
    .advance     (cmt_acc),
    .grant       (cmt_gnt),
    .grant_idx   (cmt_idx),
    .grant_valid (cmt_gv)
  );

  assign cmt_acc        = run && (cmt_st == ARB_IDLE) && cmt_gv;
  assign s_commit_ready = cmt_acc ? cmt_gnt : '0;

  always_comb begin
    cmt_st_nxt = cmt_st;
    unique case (cmt_st)
      ARB_IDLE: if (cmt_acc)        cmt_st_nxt = ARB_HOLD;
      ARB_HOLD: if (m_commit_ready) cmt_st_nxt = ARB_IDLE;
      default:                      cmt_st_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_st   <= ARB_IDLE;
      cmt_op_q <= '0;
    end else begin
      cmt_st <= cmt_st_nxt;
      if (cmt_acc) cmt_op_q <= s_commit_op_tag[cmt_idx*OP_TAG_WIDTH +: OP_TAG_WIDTH];
    end
  end

  assign m_commit_valid  = (cmt_st == ARB_HOLD);
  assign m_commit_op_tag = cmt_op_q;

  logic [CNTW-1:0] cnt [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_cnt
    logic inc, dec;
    assign inc = s_req_ready[i];
    assign dec = s_commit_ready[i] && s_commit_valid[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else if (inc && !dec && cnt[i] != CNT_MAX) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (dec && !inc && cnt[i] != '0) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end

    assign outstanding_full[i] = (cnt[i] == CNT_MAX);
  end

  logic                     rv, r_pop, r_acc, r_ok;
  logic [CLP-1:0]           r_port, r_in_port;
  logic [RESP_WIDTH-1:0]    r_data;
  logic [REQ_TAG_WIDTH-1:0] r_tag;
  logic [OP_TAG_WIDTH-1:0]  r_op;

  assign r_in_port    = s_resp_tag[REQ_TAG_WIDTH +: CLP];
  assign r_ok         = {1'b0, r_in_port} < NPORTS;
  assign r_pop        = rv && m_resp_ready[r_port];
  assign s_resp_ready = run && (!rv || r_pop);
  assign r_acc        = s_resp_valid && s_resp_ready;

  // Out-of-range ports are accepted but never loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv     <= 1'b0;
      r_port <= '0;
      r_data <= '0;
      r_tag  <= '0;
      r_op   <= '0;
    end else if (r_acc) begin
      rv     <= r_ok;
      r_port <= r_in_port;
      r_data <= s_resp_data;
      r_tag  <= s_resp_tag[REQ_TAG_WIDTH-1:0];
      r_op   <= s_resp_op_tag;
    end else if (r_pop) begin
      rv <= 1'b0;
    end
  end

  assign m_resp_valid  = rv ? (PORTS'(1) << r_port) : '0;
  assign m_resp_data   = {PORTS{r_data}};
  assign m_resp_tag    = {PORTS{r_tag}};
  assign m_resp_op_tag = {PORTS{r_op}};

endmodule

// File: doc/cpl_enqueue_arbiter.md
# cpl_enqueue_arbiter

Shares the single enqueue request/response/commit interface of the completion queue manager between `PORTS` independent completion sources, such as TX, RX and event paths. It performs round-robin arbitration on requests and commits, tags each request with its source port, and routes each response back to its originator by that tag. It sits directly in front of the queue manager's enqueue ports and enforces a per-port limit on outstanding operations.

## Interface
Parameters:
- `PORTS`, 4: number of requesters, 2..16.
- `QUEUE_INDEX_WIDTH`, 8: queue index width.
- `REQ_TAG_WIDTH`, 8: per-port request tag width.
- `OP_TAG_WIDTH`, 4: queue-manager operation tag width.
- `RESP_WIDTH`, 80: opaque response payload (addr/phase/full/error), passed through unmodified.
- `MAX_OUTSTANDING`, 8: per-port limit on accepted-but-uncommitted operations.

Ports (the `[PORTS*x]` ports are flattened, with port i in slice i):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `s_req_queue` in PORTS*QUEUE_INDEX_WIDTH; `s_req_tag` in PORTS*REQ_TAG_WIDTH; `s_req_valid` in PORTS; `s_req_ready` out PORTS: requester-side enqueue requests.
- `m_req_queue` out QUEUE_INDEX_WIDTH; `m_req_tag` out REQ_TAG_WIDTH+CL_PORTS; `m_req_valid` out 1; `m_req_ready` in 1: request to the queue manager.
- `s_resp_data` in RESP_WIDTH; `s_resp_tag` in REQ_TAG_WIDTH+CL_PORTS; `s_resp_op_tag` in OP_TAG_WIDTH; `s_resp_valid` in 1; `s_resp_ready` out 1: response from the queue manager.
- `m_resp_data` out PORTS*RESP_WIDTH; `m_resp_tag` out PORTS*REQ_TAG_WIDTH; `m_resp_op_tag` out PORTS*OP_TAG_WIDTH; `m_resp_valid` out PORTS; `m_resp_ready` in PORTS: responses to requesters.
- `s_commit_op_tag` in PORTS*OP_TAG_WIDTH; `s_commit_valid` in PORTS; `s_commit_ready` out PORTS: requester commits.
- `m_commit_op_tag` out OP_TAG_WIDTH; `m_commit_valid` out 1; `m_commit_ready` in 1: commit to the queue manager.
- `outstanding_full` out PORTS: port i is at MAX_OUTSTANDING.

`CL_PORTS` = $clog2(PORTS).

## Operation
- All handshakes are AXI-stream: a transfer occurs on valid && ready. Valid never drops, and payload never changes, before the transfer.
- **Request arbiter FSM, IDLE/HOLD:**
  - IDLE: round-robin over ports with s_req_valid && !outstanding_full, starting at last_grant+1.
  - The winner gets s_req_ready=1 for one cycle. Its payload is registered, and m_req_tag = {port_index, req_tag} with port in the MSBs. The FSM then moves to HOLD.
  - HOLD: m_req_valid=1 until m_req_ready. Then it returns to IDLE, and last_grant = winner.
  - s_req_ready is 0 for all ports in HOLD.
- **Outstanding counters:** per port, width $clog2(MAX_OUTSTANDING+1).
  - +1 on request accept; -1 on that port's commit accept.
  - Both in one cycle leaves the count unchanged.
  - The count saturates and never underflows. A commit at count 0 is still forwarded.
  - outstanding_full[i] = (count == MAX_OUTSTANDING).
- **Response demux:**
  - Port = s_resp_tag MSBs. The low REQ_TAG_WIDTH bits, data and op_tag go to that port through a one-entry register.
  - s_resp_ready = register empty, or the target port is accepting this cycle.
  - A port index ≥ PORTS is dropped: accepted, never presented.
- **Commit arbiter:** round-robin over s_commit_valid, independent pointer, one-entry output register, same IDLE/HOLD discipline as requests. The counter decrement happens at s_commit accept.
- Requests, responses and commits proceed concurrently and independently.

## Timing
- Reset values (asynchronous, on rst_n=0): all valid/ready outputs 0, FSMs IDLE, counters 0, RR pointers to PORTS-1 (port 0 first), outstanding_full 0. Payload outputs are don't-care.
- Request latency: s_req accept at cycle N gives m_req_valid at N+1. Maximum throughput is one request per 2 cycles.
- Response latency: 1 cycle. Full throughput when the port ready is held high.
- Commit latency: 1 cycle. One commit per 2 cycles.
- Reset mid-operation: in-flight held beats are discarded and counters clear. The queue manager is reset by the same domain.

## Structure
- Shared package `cpl_arb_pkg`: `CL_PORTS` function/localparam and the request/commit FSM state enum.
- One sub-module `rr_arbiter` (PORTS-wide request vector, grant one-hot plus index, advance-on-accept pointer). It is instantiated twice: request and commit.

## Test plan
- **Reset and first grant:** release reset, ports 0 and 2 request queue 0x05 → port 0 granted first, m_req_tag = {0, tag}, m_req_valid one cycle after accept.
- **Round-robin fairness:** all 4 ports request continuously with m_req_ready=1 → grant order 0,1,2,3,0, one grant every 2 cycles.
- **Backpressure:** m_req_ready=0 for 5 cycles → m_req_* stable, all s_req_ready=0, no second grant.
- **Response routing:** s_resp_tag = {2'd3, 8'hA7}, op_tag 4'h9 → m_resp_valid[3] next cycle with tag 0xA7, op_tag 0x9; other ports idle.
- **Outstanding limit:** port 1 issues 8 requests without commits → outstanding_full[1]=1 and port 1 is no longer granted. One commit → flag clears next cycle and port 1 is granted again.
- **Simultaneous accept and commit on one port:** count unchanged. Asserting rst_n=0 mid-HOLD → m_req_valid drops immediately, counters 0.
